// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: register file geometry and well-known register numbers.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP   = 5'd29;
    localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_decode32_if.sv
// Register file access bundle: one write port and two combinational read ports.
interface regfile_decode32_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);

    logic              reg_write;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_addr_a;
    logic [ADDR_W-1:0] read_addr_b;
    logic [DATA_W-1:0] read_data_a;
    logic [DATA_W-1:0] read_data_b;

    modport master (
        output reg_write, write_addr, write_data, read_addr_a, read_addr_b,
        input  read_data_a, read_data_b
    );

    modport slave (
        input  reg_write, write_addr, write_data, read_addr_a, read_addr_b,
        output read_data_a, read_data_b
    );

endinterface

// File: rtl/decoder5to32.sv
// 1-of-32 address decoder with enable; an unknown address decodes to no selection.
module decoder5to32 #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int NUM_OUT = cpu_pkg::NUM_REGS
) (
    input  logic               enable,
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_OUT-1:0] onehot
);

    // Equality compares rather than a shift so an X/Z address matches nothing.
    always_comb begin
        onehot = '0;
        if (enable) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (addr == ADDR_W'(i)) begin
                    onehot[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_decode32.sv
// 32 x 32 CPU register file: decoded single write port, two combinational read ports, r0 hardwired to zero.
module regfile_decode32 import cpu_pkg::*; #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    regfile_decode32_if.slave rf
);

    if (NUM_REGS != 2**ADDR_W) begin : g_cfg_err
        $error("regfile_decode32: NUM_REGS must equal 2**ADDR_W");
    end

    logic [NUM_REGS-1:0] we_onehot;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    decoder5to32 #(
        .ADDR_W  (ADDR_W),
        .NUM_OUT (NUM_REGS)
    ) u_wdec (
        .enable (rf.reg_write),
        .addr   (rf.write_addr),
        .onehot (we_onehot)
    );

    // Entry 0 is forced to zero here so it never holds anything but reset state.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (we_onehot[i]) begin
                regs_d[i] = rf.write_data;
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass keys off the decoded enable, so it agrees with what the edge will store.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wr_hit,
        input logic [DATA_W-1:0] wr_data,
        input logic              in_reset
    );
        logic [DATA_W-1:0] data;
        data = stored;
        if (BYPASS && wr_hit) begin
            data = wr_data;
        end
        if (in_reset || (addr == ADDR_W'(REG_ZERO))) begin
            data = '0;
        end
        return data;
    endfunction

    assign rf.read_data_a = read_port(rf.read_addr_a, regs_q[rf.read_addr_a],
                                      we_onehot[rf.read_addr_a], rf.write_data, !reset_n);
    assign rf.read_data_b = read_port(rf.read_addr_b, regs_q[rf.read_addr_b],
                                      we_onehot[rf.read_addr_b], rf.write_data, !reset_n);

endmodule

// File: tb/tb_regfile_decode32.sv
// Bench for regfile_decode32: bypassing and non-bypassing instances driven in lockstep.
module tb_regfile_decode32;

    logic        clk;
    logic        reset_n;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr_a;
    logic [4:0]  read_addr_b;

    regfile_decode32_if if_b ();
    regfile_decode32_if if_n ();

    assign if_b.reg_write   = reg_write;
    assign if_b.write_addr  = write_addr;
    assign if_b.write_data  = write_data;
    assign if_b.read_addr_a = read_addr_a;
    assign if_b.read_addr_b = read_addr_b;
    assign if_n.reg_write   = reg_write;
    assign if_n.write_addr  = write_addr;
    assign if_n.write_data  = write_data;
    assign if_n.read_addr_a = read_addr_a;
    assign if_n.read_addr_b = read_addr_b;

    regfile_decode32 #(.BYPASS(1'b1)) dut_byp (.clk(clk), .reset_n(reset_n), .rf(if_b));
    regfile_decode32 #(.BYPASS(1'b0)) dut_nob (.clk(clk), .reset_n(reset_n), .rf(if_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea_b;
        logic [31:0] eb_b;
        logic [31:0] ea_n;
        logic [31:0] eb_n;
    } vec_t;

    typedef struct {
        int          tag;
        logic [31:0] ea_b;
        logic [31:0] eb_b;
        logic [31:0] ea_n;
        logic [31:0] eb_n;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[12];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic drive(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb);
        reg_write   = we;
        write_addr  = wa;
        write_data  = wd;
        read_addr_a = ra;
        read_addr_b = rb;
    endtask

    task automatic push(input int tag, input logic [31:0] ea_b, input logic [31:0] eb_b,
                        input logic [31:0] ea_n, input logic [31:0] eb_n);
        exp_t e;
        e.tag  = tag;
        e.ea_b = ea_b;
        e.eb_b = eb_b;
        e.ea_n = ea_n;
        e.eb_n = eb_n;
        sb_q.push_back(e);
    endtask

    task automatic cmp(input string what, input int tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            $display("FAIL %s[%0d]: got %08h expected %08h", what, tag, got, want);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_pop(input string what);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty", what);
            return;
        end
        e = sb_q.pop_front();
        cmp({what, ".byp.a"}, e.tag, if_b.read_data_a, e.ea_b);
        cmp({what, ".byp.b"}, e.tag, if_b.read_data_b, e.eb_b);
        cmp({what, ".nob.a"}, e.tag, if_n.read_data_a, e.ea_n);
        cmp({what, ".nob.b"}, e.tag, if_n.read_data_b, e.eb_n);
    endtask

    function automatic logic [31:0] sweep_val(input int i);
        return 32'((i << 8) | i);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                we  wa     wd            ra     rb     byp.a         byp.b         nob.a         nob.b
        vecs[0]  = '{1'b1, 5'd8,  32'h12345678, 5'd8,  5'd9,  32'h12345678, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd9,  32'h12345678, 32'h0,        32'h12345678, 32'h0};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[4]  = '{1'b1, 5'd3,  32'h00000011, 5'd3,  5'd8,  32'h00000011, 32'h12345678, 32'h0,        32'h12345678};
        vecs[5]  = '{1'b0, 5'd3,  32'hAAAA5555, 5'd3,  5'd3,  32'h00000011, 32'h00000011, 32'h00000011, 32'h00000011};
        vecs[6]  = '{1'b0, 5'd3,  32'hAAAA5555, 5'd3,  5'd0,  32'h00000011, 32'h0,        32'h00000011, 32'h0};
        vecs[7]  = '{1'b1, 5'd31, 32'h00000001, 5'd29, 5'd31, 32'h0,        32'h00000001, 32'h0,        32'h0};
        vecs[8]  = '{1'b1, 5'd31, 32'h00000002, 5'd31, 5'd31, 32'h00000002, 32'h00000002, 32'h00000001, 32'h00000001};
        vecs[9]  = '{1'b0, 5'd31, 32'h00000002, 5'd31, 5'd8,  32'h00000002, 32'h12345678, 32'h00000002, 32'h12345678};
        vecs[10] = '{1'b1, 5'd29, 32'hCAFEF00D, 5'd29, 5'd0,  32'hCAFEF00D, 32'h0,        32'h0,        32'h0};
        vecs[11] = '{1'b0, 5'd29, 32'h0,        5'd29, 5'd31, 32'hCAFEF00D, 32'h00000002, 32'hCAFEF00D, 32'h00000002};

        // Reset state, including a write presented while reset is held.
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #2;
        drive(1'b1, 5'd5, 32'h00000055, 5'd5, 5'd0);
        push(0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1 check_pop("reset_hold");
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        push(1, 32'h0, 32'h0, 32'h0, 32'h0);
        #2 check_pop("reset_discard");

        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra, vecs[v].rb);
            push(v, vecs[v].ea_b, vecs[v].eb_b, vecs[v].ea_n, vecs[v].eb_n);
            #2 check_pop("vec");
        end

        // Decode sweep: every register gets a distinct value, then read back on both ports.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(1'b1, 5'(i), sweep_val(i), 5'd0, 5'd0);
        end
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'((i % 31) + 1));
            push(100 + i, sweep_val(i), sweep_val((i % 31) + 1),
                 sweep_val(i), sweep_val((i % 31) + 1));
            #2 check_pop("sweep");
        end

        // Asynchronous reset asserted mid-cycle clears contents with no clock edge.
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd31);
        push(200, 32'hDEADBEEF, sweep_val(31), sweep_val(5), sweep_val(31));
        #2 check_pop("rst_pre_wr");
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        push(201, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        #1 check_pop("rst_pre_rd");
        #1 reset_n = 1'b0;
        push(202, 32'h0, 32'h0, 32'h0, 32'h0);
        #1 check_pop("rst_async");
        drive(1'b1, 5'd5, 32'h00001111, 5'd5, 5'd5);
        push(203, 32'h0, 32'h0, 32'h0, 32'h0);
        #1 check_pop("rst_bypass");
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        push(204, 32'h0, 32'h0, 32'h0, 32'h0);
        #2 check_pop("rst_release");
        @(negedge clk);
        drive(1'b1, 5'd5, 32'h00000077, 5'd5, 5'd0);
        push(205, 32'h00000077, 32'h0, 32'h0, 32'h0);
        #2 check_pop("post_rst_wr");
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        push(206, 32'h00000077, 32'h0, 32'h00000077, 32'h0);
        #2 check_pop("post_rst_rd");

        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_decode32.md
Name: regfile_decode32

Overview:
- 32-entry × 32-bit register file for the Lab3 single-cycle CPU datapath.
- Sits downstream of the write-address select (rt/rd, 5-bit) and the write-data select (ALU/memory, 32-bit).
- Decodes the selected 5-bit write address into one-hot write enables; the inverse of the select path, so 1-of-32 demux/decode.
- Provides two combinational read ports feeding the ALU operands.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.
- BYPASS, 1, when 1 a read of the address being written this cycle returns write_data; when 0 it returns the stored value.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset; clears all registers.
- reg_write  input  1  write enable for the current cycle.
- write_addr  input  ADDR_W  destination register, from the write-address select.
- write_data  input  DATA_W  data to write, from the write-data select.
- read_addr_a  input  ADDR_W  read port A address (rs).
- read_addr_b  input  ADDR_W  read port B address (rt).
- read_data_a  output  DATA_W  port A data, combinational.
- read_data_b  output  DATA_W  port B data, combinational.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, reset_n.
- Reset:
  - reset_n=0 forces every register to 0 immediately, without waiting for a clock edge.
  - While reset_n=0, both read outputs are 0, BYPASS included.
  - A write presented while reset_n=0 is discarded.
  - reset_n deasserting mid-cycle has no effect until the next rising edge.
- Write decode:
  - The decoder produces we_onehot[NUM_REGS-1:0].
  - we_onehot = (1 << write_addr) when reg_write=1, otherwise all zeros.
  - Exactly zero or one enable is high in any cycle.
- Write timing: on the rising clk edge with reset_n=1, the register with its enable set loads write_data. Write latency is 1 edge.
- Register 0:
  - Hardwired to 0; writes to address 0 are ignored.
  - Reads of address 0 return 0 regardless of BYPASS or the write in flight.
- Read ports:
  - Purely combinational: read_data_x = reg[read_addr_x].
  - No clock latency; read outputs settle within the same cycle the address changes.
- Same-cycle read/write of the same address (nonzero, reg_write=1):
  - BYPASS=1: read_data shows write_data in that cycle.
  - BYPASS=0: read_data shows the old value until after the edge.
- Both ports may read the same address; both return identical values.
- Widths:
  - No arithmetic.
  - Addresses are used unsigned and are always in range, because NUM_REGS = 2**ADDR_W.
  - An X or Z on write_addr while reg_write=1 must produce no write; the decoder default is all zeros.
- No stall or handshake: a write is accepted every cycle that reg_write=1.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W=32, ADDR_W=5, NUM_REGS=32.
  - REG_ZERO=5'd0.
  - Register-name constants used by the control unit and benches: REG_RA=5'd31, REG_SP=5'd29.
- One sub-module, decoder5to32:
  - Inputs: enable (1) and addr (5).
  - Output: one-hot (32).
  - Combinational.
  - Reusable wherever the datapath needs a 1-of-32 select.
- The storage array and the read muxing stay in regfile_decode32.

Test Plan:
- Reset: drive reset_n=0 mid-cycle after writing reg 5=0xDEADBEEF -> read_data_a at addr 5 reads 0x00000000 immediately, with no clock edge.
- Basic write/read: reg_write=1, write_addr=8, write_data=0x12345678, one edge -> read_addr_a=8 returns 0x12345678; read_addr_b=9 returns 0.
- Zero register: write 0xFFFFFFFF to addr 0 -> both ports reading addr 0 return 0, before and after the edge.
- Write enable low: reg_write=0, write_addr=3, write_data=0xAAAA5555, edge -> reg 3 keeps its prior value of 0x00000011.
- Bypass: BYPASS=1, reg 31 holds 0x1, write 0x2 to addr 31 while read_addr_a=31 -> read_data_a=0x2 before the edge. With BYPASS=0 -> 0x1 before the edge, 0x2 after.
- Decode sweep: write value (i<<8)|i to each addr i=1..31, then read all 31 on both ports -> every register holds its own value, with no aliasing.
